rgb2raw_bayer: RTL and testbench

RGB2RAW_BAYER -- requirements
Module: rgb2raw_bayer

---
 rtl/rgb2raw_bayer_pkg.sv | 10 +
 rtl/rgb2raw_bayer_pixel_counter.sv | 40 ++++
 rtl/rgb2raw_bayer.sv | 96 +++++++++
 tb/tb_rgb2raw_bayer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rgb2raw_bayer_pkg.sv
// rgb2raw_pkg: shared constants, encodings and helpers for the RGB-to-Bayer converter
package rgb2raw_pkg;
    localparam int CNT_W = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = 11'd2047;
    typedef enum logic [1:0] {PH_RGGB = 2'b00, PH_GRBG = 2'b01, PH_GBRG = 2'b10, PH_BGGR = 2'b11} phase_e;
    typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} state_e;
    function automatic logic [9:0] expand(input logic [7:0] c, input logic rep);
        return rep ? {c, c[7:6]} : {c, 2'b00};
    endfunction
endpackage

// File: rtl/rgb2raw_bayer_pixel_counter.sv
// bayer_pixel_counter: saturating X/Y pixel position and per-line valid tracking
module bayer_pixel_counter
    import rgb2raw_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             vs_i,
    input  logic             hs_i,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             pix_o,
    output logic             hs_fall_o
);
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic hs_q, seen_q, seen_d;
    assign pix_o = en_i & vs_i & hs_i;
    assign hs_fall_o = hs_q & ~hs_i;
    assign x_o = x_q;
    assign y_o = y_q;
    // seen_q survives into the iHS-low cycle so the falling edge can decide on Y
    always_comb begin
        x_d = (!en_i || !hs_i) ? '0 : (pix_o && x_q != CNT_MAX) ? x_q + 1'b1 : x_q;
        y_d = (!en_i || !vs_i) ? '0 : (hs_fall_o && seen_q && y_q != CNT_MAX) ? y_q + 1'b1 : y_q;
        seen_d = en_i & hs_i & (seen_q | pix_o);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            hs_q <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            hs_q <= en_i & hs_i;
            seen_q <= seen_d;
        end
    end
endmodule

// File: rtl/rgb2raw_bayer.sv
// rgb2raw_bayer: RGB stream to 10-bit Bayer RAW with a two-cycle pipeline and line policing
module rgb2raw_bayer
    import rgb2raw_pkg::*;
#(
    parameter bit BIT_EXPAND       = 1'b1,
    parameter int D8M_VAL_LINE_MIN = 0
) (
    input  logic             VGA_CLK,
    input  logic             RESET_N,
    input  logic [7:0]       iRed,
    input  logic [7:0]       iGreen,
    input  logic [7:0]       iBlue,
    input  logic             iVS,
    input  logic             iHS,
    input  logic [1:0]       iBAYER_PHASE,
    input  logic [15:0]      LINE_MAX,
    output logic [9:0]       oDATA,
    output logic             oVS,
    output logic             oHS,
    output logic             oDVAL,
    output logic [CNT_W-1:0] oX,
    output logic [CNT_W-1:0] oY,
    output logic             oLINE_ERR
);
    state_e state_q;
    logic [1:0] ph_q, s;
    logic vs_low_q, ovr_q, en, vs_rise, pix, hs_fall, over, lo_ok;
    logic [CNT_W-1:0] x, y, x1_q, y1_q, x2_q, y2_q;
    logic [7:0] r1_q, g1_q, b1_q, c;
    logic vs1_q, hs1_q, v1_q, err1_q, vs2_q, hs2_q, v2_q, err2_q;
    logic [9:0] data_q, data_d;
    assign en = state_q == ACTIVE;
    // vs_low_q starts at 0 so a frame already running at reset release is ignored
    assign vs_rise = iVS & vs_low_q;
    bayer_pixel_counter u_cnt (
        .clk(VGA_CLK),
        .rst_n(RESET_N),
        .en_i(en),
        .vs_i(iVS),
        .hs_i(iHS),
        .x_o(x),
        .y_o(y),
        .pix_o(pix),
        .hs_fall_o(hs_fall)
    );
    generate
        if (D8M_VAL_LINE_MIN > 0) begin : g_min
            assign lo_ok = 32'(x) >= D8M_VAL_LINE_MIN;
        end else begin : g_nomin
            assign lo_ok = 1'b1;
        end
    endgenerate
    assign over = (LINE_MAX != '0) && ({5'd0, x} >= LINE_MAX);
    assign s = {y1_q[0] ^ ph_q[1], x1_q[0] ^ ph_q[0]};
    assign c = (s == 2'b00) ? r1_q : (s == 2'b11) ? b1_q : g1_q;
    assign data_d = v1_q ? expand(c, BIT_EXPAND) : '0;
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= WAIT_FRAME;
            ph_q <= PH_RGGB;
            {vs_low_q, ovr_q} <= '0;
            {r1_q, g1_q, b1_q, x1_q, y1_q, vs1_q, hs1_q, v1_q, err1_q} <= '0;
            {data_q, x2_q, y2_q, vs2_q, hs2_q, v2_q, err2_q} <= '0;
        end else begin
            if (vs_rise) begin
                state_q <= ACTIVE;
                ph_q <= iBAYER_PHASE;
            end
            vs_low_q <= ~iVS;
            ovr_q <= en & iHS & (ovr_q | (pix & over));
            r1_q <= iRed;
            g1_q <= iGreen;
            b1_q <= iBlue;
            x1_q <= x;
            y1_q <= y;
            vs1_q <= iVS;
            hs1_q <= iHS;
            v1_q <= pix & lo_ok & ~over;
            err1_q <= hs_fall & ovr_q;
            data_q <= data_d;
            x2_q <= x1_q;
            y2_q <= y1_q;
            vs2_q <= vs1_q;
            hs2_q <= hs1_q;
            v2_q <= v1_q;
            err2_q <= err1_q;
        end
    end
    assign oDATA = data_q;
    assign oVS = vs2_q;
    assign oHS = hs2_q;
    assign oDVAL = v2_q;
    assign oX = x2_q;
    assign oY = y2_q;
    assign oLINE_ERR = err2_q;
endmodule

// File: tb/tb_rgb2raw_bayer.sv
// tb_rgb2raw_bayer: directed and random frames checked against a Bayer-tile reference model
module tb_rgb2raw_bayer;
    typedef struct packed {
        logic vs, hs, dv_a, dv_b, err, xy;
        logic [9:0] data_a, data_b;
        logic [10:0] x, y;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;
    logic vs = 1'b1, hs = 1'b0;
    logic [1:0] ph = '0;
    logic [15:0] lm = '0;
    logic [9:0] data_a, data_b;
    logic vs_a, hs_a, dv_a, err_a, vs_b, hs_b, dv_b, err_b;
    logic [10:0] x_a, y_a, x_b, y_b;
    int checks = 0, passed = 0;
    exp_t q[$];
    string tile = "RGGBGRBGGBRGBGGR";

    always #5 clk = ~clk;

    rgb2raw_bayer dut_a (
        .VGA_CLK(clk), .RESET_N(rst_n), .iRed(r), .iGreen(g), .iBlue(b), .iVS(vs), .iHS(hs),
        .iBAYER_PHASE(ph), .LINE_MAX(lm), .oDATA(data_a), .oVS(vs_a), .oHS(hs_a), .oDVAL(dv_a),
        .oX(x_a), .oY(y_a), .oLINE_ERR(err_a)
    );
    rgb2raw_bayer #(.BIT_EXPAND(1'b0), .D8M_VAL_LINE_MIN(2)) dut_b (
        .VGA_CLK(clk), .RESET_N(rst_n), .iRed(r), .iGreen(g), .iBlue(b), .iVS(vs), .iHS(hs),
        .iBAYER_PHASE(ph), .LINE_MAX(lm), .oDATA(data_b), .oVS(vs_b), .oHS(hs_b), .oDVAL(dv_b),
        .oX(x_b), .oY(y_b), .oLINE_ERR(err_b)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        checks++;
        assert (obs === want) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    endtask

    task automatic check_out(exp_t e);
        chk("vs_a", 32'(vs_a), 32'(e.vs));
        chk("hs_a", 32'(hs_a), 32'(e.hs));
        chk("dval_a", 32'(dv_a), 32'(e.dv_a));
        chk("data_a", 32'(data_a), 32'(e.data_a));
        chk("err_a", 32'(err_a), 32'(e.err));
        chk("vs_b", 32'(vs_b), 32'(e.vs));
        chk("hs_b", 32'(hs_b), 32'(e.hs));
        chk("dval_b", 32'(dv_b), 32'(e.dv_b));
        chk("data_b", 32'(data_b), 32'(e.data_b));
        chk("err_b", 32'(err_b), 32'(e.err));
        if (e.xy) begin
            chk("x_a", 32'(x_a), 32'(e.x));
            chk("y_a", 32'(y_a), 32'(e.y));
            chk("x_b", 32'(x_b), 32'(e.x));
            chk("y_b", 32'(y_b), 32'(e.y));
        end
    endtask

    // Colour of site (x,y) read from the 2x2 tile named by the phase, then widened to 10 bits
    function automatic int sample(bit rep, int x, int y, int p, int rr, int gg, int bb);
        byte c;
        int v;
        c = tile[p * 4 + (y % 2) * 2 + x % 2];
        v = (c == "R") ? rr : (c == "B") ? bb : gg;
        return rep ? v * 4 + v / 64 : v * 4;
    endfunction

    function automatic exp_t blank(bit v, bit h);
        exp_t e;
        e = '0;
        e.vs = v;
        e.hs = h;
        return e;
    endfunction

    function automatic exp_t pix_exp(bit live, int x, int y, int p, int m, int rr, int gg, int bb);
        exp_t e;
        e = blank(1'b1, 1'b1);
        e.xy = live;
        e.x = 11'(x);
        e.y = 11'(y);
        e.dv_a = live && (m == 0 || x < m);
        e.dv_b = e.dv_a && x >= 2;
        e.data_a = e.dv_a ? 10'(sample(1'b1, x, y, p, rr, gg, bb)) : 10'd0;
        e.data_b = e.dv_b ? 10'(sample(1'b0, x, y, p, rr, gg, bb)) : 10'd0;
        return e;
    endfunction

    // Drive one cycle; outputs seen now belong to the input driven two cycles earlier
    task automatic step(bit v, bit h, int rr, int gg, int bb, int p, int m, exp_t e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vs = v;
        hs = h;
        r = rr[7:0];
        g = gg[7:0];
        b = bb[7:0];
        ph = p[1:0];
        lm = m[15:0];
        q.push_back(e);
        @(negedge clk);
        check_out(q.pop_front());
    endtask

    task automatic frame(int w, int h, int m, int p, bit live, bit joint, bit midph, int cr, int cg, int cb);
        int rr, gg, bb, cp;
        bit vl;
        exp_t e;
        step(1'b1, 1'b0, 0, 0, 0, p, m, blank(1'b1, 1'b0));
        for (int y = 0; y < h; y++) begin
            cp = (midph && y > 0) ? 3 - p : p;
            for (int x = 0; x < w; x++) begin
                rr = (cr < 0) ? int'($urandom_range(255)) : cr;
                gg = (cg < 0) ? int'($urandom_range(255)) : cg;
                bb = (cb < 0) ? int'($urandom_range(255)) : cb;
                step(1'b1, 1'b1, rr, gg, bb, cp, m, pix_exp(live, x, y, p, m, rr, gg, bb));
            end
            vl = !(joint && y == h - 1);
            e = blank(vl, 1'b0);
            e.err = live && m != 0 && w > m;
            step(vl, 1'b0, 0, 0, 0, cp, m, e);
            step(vl, 1'b0, 0, 0, 0, cp, m, blank(vl, 1'b0));
        end
        step(1'b0, 1'b0, 0, 0, 0, p, m, blank(1'b0, 1'b0));
        step(1'b0, 1'b1, 0, 0, 0, p, m, blank(1'b0, 1'b1));
        step(1'b0, 1'b0, 0, 0, 0, p, m, blank(1'b0, 1'b0));
    endtask

    task automatic mid_reset();
        exp_t z;
        step(1'b1, 1'b0, 0, 0, 0, 2, 0, blank(1'b1, 1'b0));
        for (int x = 0; x < 2; x++)
            step(1'b1, 1'b1, 8'h80, 8'h40, 8'hC0, 2, 0, pix_exp(1'b1, x, 0, 2, 0, 8'h80, 8'h40, 8'hC0));
        #2 rst_n = 1'b0;
        z = '0;
        z.xy = 1'b1;
        #1 check_out(z);
        q.delete();
        q.push_back('0);
        q.push_back('0);
        for (int x = 2; x < 5; x++)
            step(1'b1, 1'b1, 8'h80, 8'h40, 8'hC0, 2, 0, blank(1'b1, 1'b1));
        step(1'b1, 1'b0, 0, 0, 0, 2, 0, blank(1'b1, 1'b0));
        step(1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 2, 0, blank(1'b1, 1'b1));
        step(1'b1, 1'b0, 0, 0, 0, 2, 0, blank(1'b1, 1'b0));
        step(1'b0, 1'b0, 0, 0, 0, 2, 0, blank(1'b0, 1'b0));
        step(1'b0, 1'b0, 0, 0, 0, 2, 0, blank(1'b0, 1'b0));
    endtask

    initial begin
        exp_t z;
        int w, h, m;
        q.push_back('0);
        q.push_back('0);
        #12;
        z = '0;
        z.xy = 1'b1;
        check_out(z);
        frame(4, 2, 0, 0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h40, 8'hC0);
        frame(4, 2, 0, 0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h40, 8'hC0);
        frame(4, 2, 0, 3, 1'b1, 1'b0, 1'b1, 8'h80, 8'h40, 8'hC0);
        frame(4, 2, 0, 0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h40, 8'hC0);
        frame(5, 2, 3, 1, 1'b1, 1'b1, 1'b0, -1, -1, -1);
        frame(5, 2, 0, 2, 1'b1, 1'b0, 1'b0, -1, -1, -1);
        frame(4, 2, 0, 0, 1'b1, 1'b0, 1'b0, 8'h12, 8'hFF, 8'h34);
        mid_reset();
        frame(4, 2, 0, 3, 1'b1, 1'b0, 1'b0, 8'h80, 8'h40, 8'hC0);
        for (int i = 0; i < 20; i++) begin
            w = int'($urandom_range(8, 3));
            h = int'($urandom_range(4, 2));
            m = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(w + 1, 1));
            frame(w, h, m, int'($urandom_range(3)), 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), -1, -1, -1);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
